// File: rtl/pulse_gen.sv
// pulse_gen: programmable pulse-train generator (period / high width / burst count or continuous).
// Latency: start sampled at a clk50 edge gives pulse_out=1 right after that edge; all outputs registered.
// Backpressure: none; cfg_load is only honoured in IDLE, start is ignored while busy, stop aborts at once.
//
// Ports:
//   clk50        system clock, rising edge
//   rst_n        asynchronous active-low reset
//   cfg_load     one-cycle strobe; cfg_period/cfg_width/cfg_count/cfg_loop valid this cycle
//   cfg_period   pulse period in clk50 cycles (>= 2)
//   cfg_width    high time in clk50 cycles (1 .. period-1)
//   cfg_count    pulses per burst (>= 1 unless cfg_loop)
//   cfg_loop     1 = continuous output until stop
//   start        level; begins a run from IDLE once a valid config is held
//   stop         level; aborts a run, also blocks start in IDLE
//   pulse_out    registered pulse train
//   busy         high while a run is in progress
//   done         one-cycle strobe when a burst completes normally
//   pulses_sent  rising edges issued since the last start (wraps in loop mode)
//   cfg_err      sticky; the most recent idle cfg_load was rejected

module pulse_gen #(
  parameter int PER_W = 25,
  parameter int CNT_W = 32
) (
  input  logic             clk50,
  input  logic             rst_n,
  input  logic             cfg_load,
  input  logic [PER_W-1:0] cfg_period,
  input  logic [PER_W-1:0] cfg_width,
  input  logic [CNT_W-1:0] cfg_count,
  input  logic             cfg_loop,
  input  logic             start,
  input  logic             stop,
  output logic             pulse_out,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] pulses_sent,
  output logic             cfg_err
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_HIGH = 2'd1;
  localparam logic [1:0] ST_LOW  = 2'd2;

  // ---------------------------------------------------------------------------
  // State and shadow configuration
  // ---------------------------------------------------------------------------
  logic [1:0]       state;
  logic [PER_W-1:0] phase;       // position inside the current period, 0 .. period-1
  logic [PER_W-1:0] shd_period;
  logic [PER_W-1:0] shd_width;
  logic [CNT_W-1:0] shd_count;
  logic             shd_loop;
  logic             cfg_valid;   // a legal config has been accepted since reset

  // Next-state values
  logic [1:0]       state_d;
  logic [PER_W-1:0] phase_d;
  logic             pulse_d;
  logic             done_d;
  logic [CNT_W-1:0] sent_d;

  // ---------------------------------------------------------------------------
  // Config legality check and load qualification
  // ---------------------------------------------------------------------------
  logic cfg_ok;
  logic load_idle;

  always_comb begin
    cfg_ok = (cfg_period >= PER_W'(2)) &&
             (cfg_width  != '0)        &&
             (cfg_width  <  cfg_period) &&
             ((cfg_count != '0) || cfg_loop);
  end

  // Loads while a run is in progress are dropped entirely so the shadow
  // config stays fixed for the whole run and cfg_err keeps its last value.
  assign load_idle = cfg_load && (state == ST_IDLE);

  // ---------------------------------------------------------------------------
  // Phase bookkeeping
  // ---------------------------------------------------------------------------
  logic last_high;   // final cycle of the high portion
  logic last_low;    // final cycle of the period
  logic burst_end;   // the pulse now finishing was the last of the burst

  always_comb begin
    last_high = (phase == (shd_width  - PER_W'(1)));
    last_low  = (phase == (shd_period - PER_W'(1)));
    burst_end = !shd_loop && (pulses_sent == shd_count);
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state;
    phase_d = phase;
    pulse_d = 1'b0;
    done_d  = 1'b0;
    sent_d  = pulses_sent;

    case (state)
      ST_IDLE: begin
        // stop has priority over start, even while idle.
        if (start && !stop && cfg_valid) begin
          state_d = ST_HIGH;
          phase_d = '0;
          pulse_d = 1'b1;
          sent_d  = CNT_W'(1);
        end
      end

      ST_HIGH: begin
        if (stop) begin
          state_d = ST_IDLE;
        end else begin
          phase_d = phase + PER_W'(1);
          if (last_high) begin
            state_d = ST_LOW;
          end else begin
            pulse_d = 1'b1;
          end
        end
      end

      ST_LOW: begin
        if (stop) begin
          // An abort that coincides with burst completion suppresses done.
          state_d = ST_IDLE;
        end else if (last_low) begin
          if (burst_end) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end else begin
            // New pulse: rising edge and count update land in the same cycle.
            // In loop mode the count simply wraps to zero.
            state_d = ST_HIGH;
            phase_d = '0;
            pulse_d = 1'b1;
            sent_d  = pulses_sent + CNT_W'(1);
          end
        end else begin
          phase_d = phase + PER_W'(1);
        end
      end

      default: begin
        // Unreachable encoding: recover to a quiet idle.
        state_d = ST_IDLE;
        phase_d = '0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Run registers. Reset is asynchronous, so a reset during a high cycle pulls
  // pulse_out low immediately rather than finishing the pulse.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk50 or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      phase       <= '0;
      pulse_out   <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      pulses_sent <= '0;
    end else begin
      state       <= state_d;
      phase       <= phase_d;
      pulse_out   <= pulse_d;
      busy        <= (state_d != ST_IDLE);
      done        <= done_d;
      pulses_sent <= sent_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Shadow config, validity and error flag
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk50 or negedge rst_n) begin
    if (!rst_n) begin
      shd_period <= '0;
      shd_width  <= '0;
      shd_count  <= '0;
      shd_loop   <= 1'b0;
      cfg_valid  <= 1'b0;
      cfg_err    <= 1'b0;
    end else if (load_idle) begin
      if (cfg_ok) begin
        shd_period <= cfg_period;
        shd_width  <= cfg_width;
        shd_count  <= cfg_count;
        shd_loop   <= cfg_loop;
        cfg_valid  <= 1'b1;
        cfg_err    <= 1'b0;
      end else begin
        // Rejected: keep the previous (possibly valid) config usable.
        cfg_err    <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pulse_gen.sv
module tb_pulse_gen;

  localparam int PER_W = 8;
  localparam int CNT_W = 4;

  logic             clk50 = 1'b0;
  logic             rst_n;
  logic             cfg_load;
  logic [PER_W-1:0] cfg_period;
  logic [PER_W-1:0] cfg_width;
  logic [CNT_W-1:0] cfg_count;
  logic             cfg_loop;
  logic             start;
  logic             stop;
  logic             pulse_out;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] pulses_sent;
  logic             cfg_err;

  pulse_gen #(.PER_W(PER_W), .CNT_W(CNT_W)) dut (
    .clk50       (clk50),
    .rst_n       (rst_n),
    .cfg_load    (cfg_load),
    .cfg_period  (cfg_period),
    .cfg_width   (cfg_width),
    .cfg_count   (cfg_count),
    .cfg_loop    (cfg_loop),
    .start       (start),
    .stop        (stop),
    .pulse_out   (pulse_out),
    .busy        (busy),
    .done        (done),
    .pulses_sent (pulses_sent),
    .cfg_err     (cfg_err)
  );

  always #5 clk50 = ~clk50;

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Reference model: a run is described by the number of cycles elapsed since
  // its first high cycle; pulse level and pulse count follow by division.
  bit         m_run, m_valid, m_err, m_done, m_loop;
  int         m_e, m_period, m_width, m_count;
  logic [CNT_W-1:0] m_sent;

  task automatic model_reset();
    m_run = 0; m_valid = 0; m_err = 0; m_done = 0; m_loop = 0;
    m_e = 0; m_period = 0; m_width = 0; m_count = 0; m_sent = '0;
  endtask

  task automatic model_step();
    bit old_valid;
    bit old_run;
    old_valid = m_valid;
    old_run   = m_run;
    m_done    = 0;
    if (cfg_load && !old_run) begin
      if (cfg_period >= 2 && cfg_width >= 1 && cfg_width < cfg_period &&
          (cfg_count != 0 || cfg_loop)) begin
        m_period = int'(cfg_period);
        m_width  = int'(cfg_width);
        m_count  = int'(cfg_count);
        m_loop   = cfg_loop;
        m_valid  = 1;
        m_err    = 0;
      end else begin
        m_err = 1;
      end
    end
    if (!old_run) begin
      if (start && !stop && old_valid) begin
        m_run = 1; m_e = 0; m_sent = 1;
      end
    end else if (stop) begin
      m_run = 0;
    end else begin
      int e_next;
      e_next = m_e + 1;
      if (!m_loop && e_next == m_count * m_period) begin
        m_run = 0; m_done = 1;
      end else begin
        m_e = e_next;
        if (e_next % m_period == 0) m_sent = m_sent + 1'b1;
      end
    end
  endtask

  task automatic check_all();
    bit exp_pulse;
    exp_pulse = 0;
    if (m_run) exp_pulse = ((m_e % m_period) < m_width);
    check_val("pulse_out",   32'(pulse_out),   32'(exp_pulse));
    check_val("busy",        32'(busy),        32'(m_run));
    check_val("done",        32'(done),        32'(m_done));
    check_val("pulses_sent", 32'(pulses_sent), 32'(m_sent));
    check_val("cfg_err",     32'(cfg_err),     32'(m_err));
  endtask

  task automatic tick();
    model_step();
    @(posedge clk50);
    #1;
    cyc++;
    check_all();
  endtask

  task automatic do_load(input int p, input int w, input int c, input bit lp);
    cfg_load   = 1'b1;
    cfg_period = PER_W'(p);
    cfg_width  = PER_W'(w);
    cfg_count  = CNT_W'(c);
    cfg_loop   = lp;
    tick();
    cfg_load   = 1'b0;
  endtask

  initial begin
    bit done_seen;
    bit wrap_seen;
    logic [CNT_W-1:0] prev_sent;
    bit exp_hi;

    rst_n = 1'b0; cfg_load = 0; cfg_period = '0; cfg_width = '0; cfg_count = '0;
    cfg_loop = 0; start = 0; stop = 0;
    model_reset();
    #1;
    check_all();                       // reset state
    #21 rst_n = 1'b1;                  // release between edges

    // Rejected load (width == period) right after reset; start must do nothing.
    do_load(10, 10, 4, 0);
    check_val("r033_err", 32'(cfg_err), 32'd1);
    start = 1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check_val("r033_busy", 32'(busy), 32'd0);
    end
    start = 0;
    tick();

    // Standard burst with an ignored mid-run load.
    do_load(10, 3, 4, 0);
    check_val("r032_err0", 32'(cfg_err), 32'd0);
    start = 1;
    tick();                            // now observing T+1
    start = 0;
    for (int k = 1; k <= 45; k++) begin
      exp_hi = (k >= 1 && k <= 3) || (k >= 11 && k <= 13) ||
               (k >= 21 && k <= 23) || (k >= 31 && k <= 33);
      check_val("r032_pulse", 32'(pulse_out), 32'(exp_hi));
      check_val("r032_done",  32'(done),      32'(k == 41));
      if (k == 5) begin
        cfg_load = 1; cfg_period = 8'd4; cfg_width = 8'd1; cfg_count = 4'd1; cfg_loop = 0;
      end else begin
        cfg_load = 0;
      end
      if (k < 45) tick();
    end
    check_val("r032_sent", 32'(pulses_sent), 32'd4);
    check_val("r036_err",  32'(cfg_err),     32'd0);

    // start and stop together while idle: stop wins.
    start = 1; stop = 1;
    tick();
    check_val("r027_busy", 32'(busy), 32'd0);
    start = 0; stop = 0;

    // Loop mode aborted by stop at T+25.
    do_load(10, 5, 0, 1);
    start = 1;
    tick();
    start = 0;
    done_seen = 0;
    for (int k = 1; k <= 25; k++) begin
      if (done) done_seen = 1;
      if (k == 25) stop = 1;
      tick();
    end
    stop = 0;
    check_val("r034_pulse", 32'(pulse_out),   32'd0);
    check_val("r034_busy",  32'(busy),        32'd0);
    check_val("r034_sent",  32'(pulses_sent), 32'd3);
    check_val("r034_done",  32'(done_seen | done), 32'd0);

    // Minimum legal config.
    do_load(2, 1, 1, 0);
    start = 1;
    tick();
    start = 0;
    check_val("r035_t1", 32'(pulse_out), 32'd1);
    tick();
    check_val("r035_t2", 32'(pulse_out), 32'd0);
    tick();
    check_val("r035_done", 32'(done), 32'd1);

    // pulses_sent wraps silently in loop mode.
    do_load(2, 1, 0, 1);
    start = 1;
    tick();
    start = 0;
    wrap_seen = 0;
    for (int k = 0; k < 40; k++) begin
      prev_sent = pulses_sent;
      tick();
      if (prev_sent == 4'hF && pulses_sent == 4'h0) wrap_seen = 1;
    end
    check_val("r025_wrap", 32'(wrap_seen), 32'd1);
    stop = 1;
    tick();
    stop = 0;

    // Randomised traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      int p;
      cfg_load = ($urandom_range(99) < 6);
      if (cfg_load) begin
        p = int'($urandom_range(12, 1));
        cfg_period = PER_W'(p);
        cfg_width  = PER_W'($urandom_range(p, 0));
        cfg_count  = CNT_W'($urandom_range(5, 0));
        cfg_loop   = ($urandom_range(3) == 0);
      end
      start = ($urandom_range(99) < 15);
      stop  = ($urandom_range(99) < 3);
      tick();
    end
    cfg_load = 0; start = 0; stop = 0;

    // Reset in the middle of a high cycle.
    do_load(10, 5, 3, 0);
    start = 1;
    tick();
    start = 0;
    tick();                            // second high cycle
    rst_n = 1'b0;
    #1;
    check_val("r037_pulse", 32'(pulse_out),   32'd0);
    check_val("r037_busy",  32'(busy),        32'd0);
    check_val("r037_sent",  32'(pulses_sent), 32'd0);
    model_reset();
    check_all();
    #2 rst_n = 1'b1;
    start = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_val("r037_nostart", 32'(busy), 32'd0);
    end
    start = 0;
    do_load(4, 2, 1, 0);
    start = 1;
    tick();
    start = 0;
    check_val("r037_restart", 32'(busy), 32'd1);
    for (int i = 0; i < 6; i++) tick();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
